int_ctrl: RTL

- Parametrised, memory-mapped interrupt controller on the CPU bridge. Replaces the single raw `interrupt` pin with N_SRC external sources.
- Per source: synchronisation, level or edge capture, pending latch, mask, and fixed-priority encoding.
- Drives the CP0 HWInt lines and a single summary irq.
- Software can set and clear pending bits over the bridge. The bench can therefore raise interrupts deterministically without the external pin.

---
 rtl/int_ctrl_pkg.sv | 16 +
 rtl/int_sync_edge.sv | 35 +++
 rtl/int_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the memory-mapped interrupt controller.
// Register word indices, capture modes and default source count.
package int_ctrl_pkg;

  localparam int N_SRC_DEF = 6;

  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_MASK  = 3'd1;
  localparam logic [2:0] REG_MODE  = 3'd2;
  localparam logic [2:0] REG_SWSET = 3'd3;
  localparam logic [2:0] REG_CLAIM = 3'd4;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/int_sync_edge.sv
// Per-source synchroniser with level/edge capture select.
// s_d keeps tracking in both modes so a mode flip never fakes an edge.
module int_sync_edge
  import int_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src_in,
  input  logic mode,
  output logic hw_set
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sd;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_sd   <= 1'b0;
    end else begin
      r_sync[0] <= src_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_sd <= w_s;
    end
  end

  assign hw_set = (mode == MODE_EDGE) ? (w_s & ~r_sd) : w_s;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending/mask/mode registers, SW set/clear,
// fixed priority (lowest index wins), registered HWInt/irq/irq_id.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC       = N_SRC_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src_in,
  input  logic             we,
  input  logic [4:0]       addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       byteen,
  output logic [31:0]      rdata,
  output logic [N_SRC-1:0] hwint,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id
);

  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_hwint;
  logic             r_irq;
  logic [ID_W-1:0]  r_id;

  logic [N_SRC-1:0] w_hw_set;
  logic [N_SRC-1:0] w_sw_set;
  logic [N_SRC-1:0] w_clr;
  logic [N_SRC-1:0] w_act;
  logic [N_SRC-1:0] w_wd;
  logic [ID_W-1:0]  w_id;
  logic [2:0]       w_idx;
  logic             w_wr;
  logic             w_unused;

  assign w_idx    = addr[4:2];
  assign w_wd     = wdata[N_SRC-1:0];
  assign w_wr     = we && (byteen == 4'b1111);
  assign w_unused = ^{wdata, addr[1:0]};

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    int_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .src_in (src_in[g]),
      .mode   (r_mode[g]),
      .hw_set (w_hw_set[g])
    );
  end

  assign w_clr    = (w_wr && w_idx == REG_PEND)  ? w_wd : '0;
  assign w_sw_set = (w_wr && w_idx == REG_SWSET) ? w_wd : '0;
  assign w_act    = r_pend & r_mask;

  always_comb begin
    w_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (w_act[i]) w_id = ID_W'(i + 1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend  <= '0;
      r_mask  <= '0;
      r_mode  <= '0;
      r_hwint <= '0;
      r_irq   <= 1'b0;
      r_id    <= '0;
    end else begin
      // set wins over clear so no event is lost
      r_pend  <= (r_pend & ~w_clr) | w_hw_set | w_sw_set;
      if (w_wr && w_idx == REG_MASK) r_mask <= w_wd;
      if (w_wr && w_idx == REG_MODE) r_mode <= w_wd;
      r_hwint <= w_act;
      r_irq   <= |w_act;
      r_id    <= w_id;
    end
  end

  always_comb begin
    rdata = '0;
    case (w_idx)
      REG_PEND:  rdata[N_SRC-1:0] = r_pend;
      REG_MASK:  rdata[N_SRC-1:0] = r_mask;
      REG_MODE:  rdata[N_SRC-1:0] = r_mode;
      REG_CLAIM: rdata[ID_W-1:0]  = r_id;
      default:   rdata = '0;
    endcase
  end

  assign hwint  = r_hwint;
  assign irq    = r_irq;
  assign irq_id = r_id;

endmodule
